count_seq_chk: RTL
==================

Name: count_seq_chk

Overview:
Parametrised multi-channel counter-sequence checker. It is the successor to the single-count "count == prev+1" checking used in our assertion examples. Each channel watches a sampled counter value and compares it against the expected next value, computed with explicit WIDTH-bit modulo arithmetic. The block sits beside any DUT counter as a synthesizable monitor and reports per-sample error pulses, sticky flags and saturating error counts.

Parameters:
WIDTH, 4, bit width of each monitored counter
NUM_CH, 2, number of independent channels
STEP, 1, increment/decrement magnitude; must satisfy 1 <= STEP < 2**WIDTH
WRAP_EN, 1, 1 = modulo wrap is legal; 0 = any wrap is an error
ERR_CNT_W, 8, width of each per-channel saturating error counter

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
valid  in  NUM_CH  per-channel sample strobe
count  in  NUM_CH*WIDTH  packed samples; channel i occupies bits [i*WIDTH +: WIDTH]
mode  in  NUM_CH  per-channel direction: 0 = up, 1 = down; sampled together with valid
clear  in  NUM_CH  per-channel synchronous clear
locked  out  NUM_CH  channel holds a reference value
err_pulse  out  NUM_CH  one-cycle mismatch indication
err_sticky  out  NUM_CH  set on mismatch, held until clear or reset
err_cnt  out  NUM_CH*ERR_CNT_W  packed saturating mismatch counts
exp_count  out  NUM_CH*WIDTH  packed expected next value (debug)

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, every prev register is 0, every channel is in S_IDLE.
- Per-channel FSM, with channels fully independent:
  - S_IDLE: on valid, capture prev := count, go to S_TRACK, set locked. No check is performed.
  - S_TRACK: on valid, compare count with exp; then prev := count unconditionally (resync on error).
  - Without valid, state and prev hold.
- exp is computed as follows:
  - mode 0: WIDTH'(prev + STEP).
  - mode 1: WIDTH'(prev - STEP).
  - Both are truncated to WIDTH bits before comparison. A result promoted to WIDTH+1 bits must never reach the comparator; for example, prev = 4'hF up gives exp = 4'h0.
- Wrap detection:
  - Up wrap: prev + STEP >= 2**WIDTH.
  - Down wrap: prev < STEP.
  - If WRAP_EN = 0 and a wrap occurs, the sample is an error even when count == exp.
- Mismatch = (count != exp) or the illegal-wrap condition.
- Latency: err_pulse, err_sticky and err_cnt update on the clock edge that samples the offending valid, so they are visible the cycle after the sample.
  - err_pulse is high for exactly one cycle per bad sample; back-to-back bad samples keep it high on consecutive cycles.
  - err_cnt increments by 1 per mismatch and saturates at 2**ERR_CNT_W - 1 (no wrap).
- exp_count is a registered copy of exp for the current prev and mode; it is 0 in S_IDLE.
- clear: go to S_IDLE and zero locked, err_sticky, err_cnt, err_pulse, prev and exp_count.
  - clear has priority over a simultaneous valid, and that sample is discarded.
- A mode change mid-stream is legal: the compare uses the mode presented with the current valid.
- Reset asserted mid-operation aborts immediately; the first valid after reset release only re-locks the channel and is never checked.

Decomposition:
- Package count_seq_pkg holds:
  - typedef enum {S_IDLE, S_TRACK} ch_state_e
  - typedef enum logic {MODE_UP, MODE_DOWN} dir_e
  - a parameterised function next_exp(prev, dir) returning the WIDTH-truncated value plus the wrap flag
- Sub-module count_seq_chk_ch implements one channel (FSM, prev, compare, counter).
- The top-level generate-instantiates NUM_CH copies and packs/unpacks the buses.
- Concurrent assertions are bound at top level:
  - err_pulse implies err_sticky.
  - err_cnt is non-decreasing until clear.
  - locked implies the channel state is S_TRACK.

Test Plan:
1. Defaults; ch0 valid with 0,1,2,3 in mode 0 -> locked[0]=1 after the first sample, err_pulse never high, err_cnt[0]=0, exp_count[0]=4 after the last sample.
2. WRAP_EN=1; ch0 with 14,15,0 -> no error and exp after 15 is 4'h0. Repeat with WRAP_EN=0 -> err_pulse[0] for one cycle after sample 0, err_cnt[0]=1.
3. Skip on ch1: 3,5,6 -> err_pulse[1] one cycle after 5, err_sticky[1]=1, err_cnt[1]=1; sample 6 passes due to resync; ch0 unaffected.
4. Mode 1 on ch0: 2,1,0,15 with WRAP_EN=1 -> no error; then 15,15 -> one error.
5. ERR_CNT_W=2; five consecutive bad samples -> err_cnt saturates at 3, err_pulse high five cycles. Then clear plus valid in the same cycle -> locked=0, counts 0, that sample ignored.
6. rst_n pulsed low between two edges mid-stream (asynchronously) -> all outputs 0 immediately; the next sample after release re-locks without error.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and next-value arithmetic for the counter-sequence checker.
package count_seq_pkg;

    typedef enum logic {S_IDLE, S_TRACK} ch_state_e;
    typedef enum logic {MODE_UP, MODE_DOWN} dir_e;

    localparam int unsigned MAX_W = 32;

    typedef struct packed {
        logic             wrap;
        logic [MAX_W-1:0] value;
    } next_t;

    // Computes in MAX_W+1 bits, then masks to width so the carry/borrow
    // never leaks into the value handed to the comparator.
    function automatic next_t next_exp(input logic [MAX_W-1:0] prev,
                                       input dir_e             dir,
                                       input int unsigned      width,
                                       input int unsigned      step);
        logic [MAX_W:0]   lim;
        logic [MAX_W:0]   full;
        logic [MAX_W-1:0] mask;
        next_t            r;
        lim  = (MAX_W+1)'(1) << width;
        mask = MAX_W'(lim - 1'b1);
        if (dir == MODE_UP) begin
            full   = {1'b0, prev} + (MAX_W+1)'(step);
            r.wrap = (full >= lim);
        end else begin
            full   = {1'b0, prev} - (MAX_W+1)'(step);
            r.wrap = (prev < MAX_W'(step));
        end
        r.value = full[MAX_W-1:0] & mask;
        return r;
    endfunction

endpackage

// File: rtl/count_seq_chk_ch.sv
// One checker channel: lock FSM, reference register, compare and error counter.
module count_seq_chk_ch
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned STEP      = 1,
    parameter int unsigned WRAP_EN   = 1,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     count,
    input  logic                 mode,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     exp_count,
    output ch_state_e            state
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] prev;
    next_t            exp_cur;
    next_t            exp_new;
    logic             mismatch;
    logic             unused_exp;

    always_comb begin
        exp_cur  = next_exp(MAX_W'(prev), dir_e'(mode), WIDTH, STEP);
        exp_new  = next_exp(MAX_W'(count), dir_e'(mode), WIDTH, STEP);
        mismatch = (MAX_W'(count) != exp_cur.value) || ((WRAP_EN == 0) && exp_cur.wrap);
    end

    assign unused_exp = ^{exp_new.wrap, exp_new.value[MAX_W-1:WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prev       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            exp_count  <= '0;
        end else if (clear) begin
            state      <= S_IDLE;
            prev       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            exp_count  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (valid) begin
                // prev always follows the sample so one skip yields one error
                prev      <= count;
                exp_count <= exp_new.value[WIDTH-1:0];
                if (state == S_IDLE) begin
                    state  <= S_TRACK;
                    locked <= 1'b1;
                end else if (mismatch) begin
                    err_pulse  <= 1'b1;
                    err_sticky <= 1'b1;
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/count_seq_chk.sv
// Multi-channel counter-sequence checker: NUM_CH independent channels on packed buses.
module count_seq_chk
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned STEP      = 1,
    parameter int unsigned WRAP_EN   = 1,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             valid,
    input  logic [NUM_CH*WIDTH-1:0]       count,
    input  logic [NUM_CH-1:0]             mode,
    input  logic [NUM_CH-1:0]             clear,
    output logic [NUM_CH-1:0]             locked,
    output logic [NUM_CH-1:0]             err_pulse,
    output logic [NUM_CH-1:0]             err_sticky,
    output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt,
    output logic [NUM_CH*WIDTH-1:0]       exp_count
);

    ch_state_e state [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ERR_CNT_W-1:0] cnt_last;
        logic                 clr_last;

        count_seq_chk_ch #(
            .WIDTH    (WIDTH),
            .STEP     (STEP),
            .WRAP_EN  (WRAP_EN),
            .ERR_CNT_W(ERR_CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid     (valid[i]),
            .count     (count[i*WIDTH +: WIDTH]),
            .mode      (mode[i]),
            .clear     (clear[i]),
            .locked    (locked[i]),
            .err_pulse (err_pulse[i]),
            .err_sticky(err_sticky[i]),
            .err_cnt   (err_cnt[i*ERR_CNT_W +: ERR_CNT_W]),
            .exp_count (exp_count[i*WIDTH +: WIDTH]),
            .state     (state[i])
        );

        // Shadow of the previous count; async reset keeps it valid across a reset pulse
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_last <= '0;
                clr_last <= 1'b0;
            end else begin
                cnt_last <= err_cnt[i*ERR_CNT_W +: ERR_CNT_W];
                clr_last <= clear[i];
            end
        end

        a_pulse_sticky: assert property (@(posedge clk) disable iff (!rst_n)
            err_pulse[i] |-> err_sticky[i]);
        a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
            clr_last || (err_cnt[i*ERR_CNT_W +: ERR_CNT_W] >= cnt_last));
        a_lock_track: assert property (@(posedge clk) disable iff (!rst_n)
            locked[i] |-> (state[i] == S_TRACK));
    end

endmodule
